// File: rtl/audio_dma_if.sv
// Bus bundle for audio_dma.
// cfg_*: zero-wait APB slave used by software to program the DMA.
// mem_*: req/ack read port into memory (req held until the one-cycle ack).
// aud_*: APB master port into the audio DAC controller stream register.
// master modport is the DMA side; slave modport is the environment side.
interface audio_dma_if;
   logic [3:0]  cfg_PADDR;
   logic        cfg_PSEL;
   logic        cfg_PENABLE;
   logic        cfg_PWRITE;
   logic [31:0] cfg_PWDATA;
   logic [31:0] cfg_PRDATA;
   logic        cfg_PREADY;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic [2:0]  aud_PADDR;
   logic        aud_PSEL;
   logic        aud_PENABLE;
   logic        aud_PWRITE;
   logic [31:0] aud_PWDATA;
   logic [31:0] aud_PRDATA;
   logic        aud_PREADY;

   modport master (
      input  cfg_PADDR, cfg_PSEL, cfg_PENABLE, cfg_PWRITE, cfg_PWDATA,
      output cfg_PRDATA, cfg_PREADY,
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      output aud_PADDR, aud_PSEL, aud_PENABLE, aud_PWRITE, aud_PWDATA,
      input  aud_PRDATA, aud_PREADY
   );

   modport slave (
      output cfg_PADDR, cfg_PSEL, cfg_PENABLE, cfg_PWRITE, cfg_PWDATA,
      input  cfg_PRDATA, cfg_PREADY,
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      input  aud_PADDR, aud_PSEL, aud_PENABLE, aud_PWRITE, aud_PWDATA,
      output aud_PRDATA, aud_PREADY
   );
endinterface

// File: rtl/audio_dma.sv
// audio_dma: fetches LEN stereo words from BASE and streams them into the
// audio DAC controller, pacing pushes by polling its FIFO free-space count.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low
//   bus       audio_dma_if.master (cfg APB slave, mem read port, aud APB master)
//   interrupt level, registered copy of done & irq_en
module audio_dma #(
   parameter logic [2:0]  STREAM_ADDR = 3'd4,
   parameter int unsigned MAX_CREDIT  = 16,
   parameter int unsigned POLL_GAP    = 2
) (
   input  logic        clk,
   input  logic        reset,
   audio_dma_if.master bus,
   output logic        interrupt
);

   localparam int unsigned CREDIT_W = $clog2(MAX_CREDIT + 1);
   localparam int unsigned GAP_W    = $clog2(POLL_GAP + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POLL_S, S_POLL_A, S_FETCH, S_PUSH_S, S_PUSH_A, S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic                en_q, loop_q, irq_en_q;
   logic [29:0]         base_q;
   logic [15:0]         len_q;
   logic                done_q, done_d, done_set;
   logic [15:0]         pushed_q, pushed_d;
   logic [15:0]         ptr_q, ptr_d;
   logic [CREDIT_W-1:0] credit_q, credit_d, poll_credit;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [31:0]         data_q, data_d;
   logic                abort_q, abort_d;
   logic [31:0]         prdata_q, rd_mux;

   logic                mem_req_q, mem_req_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [2:0]          paddr_q, paddr_d;
   logic [31:0]         pwdata_q, pwdata_d;
   logic                irq_q;

   logic                cfg_wr, wr_ctrl, wr_base, wr_len, wr_status;
   logic                start, abort_req, abort_now, last_word;
   logic                unused_ok;

   assign unused_ok = ^{bus.aud_PRDATA[31:10], en_q};

   // Config APB decode; accesses complete in the single access-phase cycle.
   assign cfg_wr    = bus.cfg_PSEL & bus.cfg_PENABLE & bus.cfg_PWRITE;
   assign wr_ctrl   = cfg_wr && (bus.cfg_PADDR == 4'h0);
   assign wr_base   = cfg_wr && (bus.cfg_PADDR == 4'h4);
   assign wr_len    = cfg_wr && (bus.cfg_PADDR == 4'h8);
   assign wr_status = cfg_wr && (bus.cfg_PADDR == 4'hC);
   assign start     = wr_ctrl && bus.cfg_PWDATA[0] && (state_q == S_IDLE);
   assign abort_req = wr_ctrl && !bus.cfg_PWDATA[0] && (state_q != S_IDLE);
   assign abort_now = abort_q | abort_req;

   assign poll_credit = (bus.aud_PRDATA[9:0] > 10'(MAX_CREDIT)) ?
                        CREDIT_W'(MAX_CREDIT) : CREDIT_W'(bus.aud_PRDATA[9:0]);
   assign last_word   = ((ptr_q + 16'd1) == len_q);

   // Software-visible control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q     <= 1'b0;
         loop_q   <= 1'b0;
         irq_en_q <= 1'b0;
         base_q   <= '0;
         len_q    <= '0;
      end else begin
         if (wr_ctrl) begin
            en_q     <= bus.cfg_PWDATA[0];
            loop_q   <= bus.cfg_PWDATA[1];
            irq_en_q <= bus.cfg_PWDATA[2];
         end
         if (wr_base) base_q <= bus.cfg_PWDATA[31:2];
         if (wr_len)  len_q  <= bus.cfg_PWDATA[15:0];
      end
   end

   // Next-state, datapath and next-output logic
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      credit_d  = credit_q;
      gap_d     = gap_q;
      data_d    = data_q;
      pushed_d  = pushed_q;
      abort_d   = abort_now;
      done_set  = 1'b0;

      case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            if (start) begin
               if (len_q == 16'd0) begin
                  done_set = 1'b1;
               end else begin
                  ptr_d    = '0;
                  credit_d = '0;
                  pushed_d = '0;
                  state_d  = S_POLL_S;
               end
            end
         end
         S_POLL_S: state_d = S_POLL_A;
         S_POLL_A: begin
            if (bus.aud_PREADY) begin
               credit_d = poll_credit;
               gap_d    = '0;
               if (abort_now)                      state_d = S_IDLE;
               else if (poll_credit == CREDIT_W'(0)) state_d = S_GAP;
               else                                state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.mem_ack) begin
               data_d  = bus.mem_rdata;
               state_d = abort_now ? S_IDLE : S_PUSH_S;
            end
         end
         S_PUSH_S: state_d = S_PUSH_A;
         S_PUSH_A: begin
            if (bus.aud_PREADY) begin
               pushed_d = pushed_q + 16'd1;
               credit_d = credit_q - CREDIT_W'(1);
               ptr_d    = last_word ? 16'd0 : ptr_q + 16'd1;
               gap_d    = '0;
               if (abort_now) begin
                  state_d = S_IDLE;
               end else if (last_word && !loop_q) begin
                  done_set = 1'b1;
                  state_d  = S_IDLE;
               end else if (credit_q == CREDIT_W'(1)) begin
                  state_d = S_GAP;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_GAP: begin
            if (abort_now)                          state_d = S_IDLE;
            else if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL_S;
            else                                    gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE) abort_d = 1'b0;

      // Set beats a simultaneous software clear.
      done_d = done_q;
      if (wr_status && bus.cfg_PWDATA[1]) done_d = 1'b0;
      if (done_set)                       done_d = 1'b1;

      // Outputs are registered copies of the decode of the next state.
      psel_d    = (state_d == S_POLL_S) || (state_d == S_POLL_A) ||
                  (state_d == S_PUSH_S) || (state_d == S_PUSH_A);
      penable_d = (state_d == S_POLL_A) || (state_d == S_PUSH_A);
      pwrite_d  = (state_d == S_PUSH_S) || (state_d == S_PUSH_A);
      paddr_d   = psel_d ? STREAM_ADDR : 3'd0;
      pwdata_d  = pwrite_d ? data_d : 32'd0;
      mem_req_d = (state_d == S_FETCH);
      // Address frozen for the whole request so BASE writes cannot disturb it.
      if (!mem_req_d)              mem_addr_d = 32'd0;
      else if (state_q == S_FETCH) mem_addr_d = mem_addr_q;
      else                         mem_addr_d = {base_q, 2'b00} + {14'd0, ptr_d, 2'b00};
   end

   // Config read mux, sampled in the setup phase for a zero-wait access phase
   always_comb begin
      case (bus.cfg_PADDR)
         4'h0:    rd_mux = {29'd0, irq_en_q, loop_q, en_q};
         4'h4:    rd_mux = {base_q, 2'b00};
         4'h8:    rd_mux = {16'd0, len_q};
         4'hC:    rd_mux = {pushed_q, 14'd0, done_q, (state_q != S_IDLE)};
         default: rd_mux = 32'd0;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         credit_q   <= '0;
         gap_q      <= '0;
         data_q     <= '0;
         pushed_q   <= '0;
         abort_q    <= 1'b0;
         done_q     <= 1'b0;
         irq_q      <= 1'b0;
         prdata_q   <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         credit_q   <= credit_d;
         gap_q      <= gap_d;
         data_q     <= data_d;
         pushed_q   <= pushed_d;
         abort_q    <= abort_d;
         done_q     <= done_d;
         irq_q      <= done_q & irq_en_q;
         if (bus.cfg_PSEL && !bus.cfg_PENABLE) prdata_q <= rd_mux;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
      end
   end

   assign bus.cfg_PRDATA  = prdata_q;
   assign bus.cfg_PREADY  = 1'b1;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.aud_PADDR   = paddr_q;
   assign bus.aud_PSEL    = psel_q;
   assign bus.aud_PENABLE = penable_q;
   assign bus.aud_PWRITE  = pwrite_q;
   assign bus.aud_PWDATA  = pwdata_q;
   assign interrupt       = irq_q;

endmodule

// File: tb/tb_audio_dma.sv
// Self-checking bench for audio_dma: memory and DAC-controller responders,
// a passive monitor building event logs, and a directed/randomized sequence
// compared against address/data/credit expectations computed from the rules.
module tb_audio_dma;
   localparam int POLL_GAP   = 2;
   localparam int MAX_CREDIT = 16;

   logic clk = 1'b0;
   logic reset;
   logic irq;

   audio_dma_if bus();

   audio_dma dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .interrupt (irq)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mem_arr [64];
   int  remaining, zero_until, mem_delay;
   bit  stall_push;

   // Monitor-owned logs and counters
   logic [31:0] rd_q [$];
   logic [31:0] wr_q [$];
   int  gap_q [$];
   int  cyc = 0, polls = 0, credit_left = 0, last_push = 0, act_cycles = 0;
   int  ovf = 0, req_no_credit = 0, proto_viol = 0, addr_unstable = 0;
   bit  have_push = 0, prev_apb_pend = 0, prev_pwrite = 0, prev_mem_pend = 0;
   logic [31:0] prev_maddr = 0;
   int  wcnt = 0;

   // Controller model: reports remaining (0 for the first zero_until polls).
   assign bus.aud_PRDATA = (polls < zero_until) ? 32'd0 : 32'(remaining);
   assign bus.aud_PREADY = !(stall_push && bus.aud_PWRITE);

   // Memory model: ack after mem_delay wait cycles, one cycle wide.
   always @(negedge clk) begin
      if (!reset) begin
         bus.mem_ack <= 1'b0;
         wcnt        <= 0;
      end else if (bus.mem_ack) begin
         bus.mem_ack <= 1'b0;
         wcnt        <= 0;
      end else if (bus.mem_req) begin
         if (wcnt >= mem_delay) begin
            bus.mem_ack   <= 1'b1;
            bus.mem_rdata <= mem_arr[bus.mem_addr[7:2]];
         end else begin
            wcnt <= wcnt + 1;
         end
      end
   end

   // Passive monitor
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         prev_apb_pend <= 1'b0;
         prev_mem_pend <= 1'b0;
      end else begin
         if (bus.aud_PSEL || bus.mem_req) act_cycles <= act_cycles + 1;
         if (bus.mem_req && bus.mem_ack) rd_q.push_back(bus.mem_addr);
         if (bus.mem_req && credit_left == 0) req_no_credit <= req_no_credit + 1;
         if (bus.aud_PSEL && bus.aud_PENABLE && bus.aud_PREADY) begin
            if (bus.aud_PWRITE) begin
               wr_q.push_back(bus.aud_PWDATA);
               if (credit_left <= 0) ovf <= ovf + 1;
               credit_left <= credit_left - 1;
               last_push   <= cyc;
               have_push   <= 1'b1;
            end else begin
               polls       <= polls + 1;
               credit_left <= (bus.aud_PRDATA[9:0] > 10'(MAX_CREDIT)) ?
                              MAX_CREDIT : int'(bus.aud_PRDATA[9:0]);
            end
         end
         if (bus.aud_PSEL && !bus.aud_PENABLE && !bus.aud_PWRITE && have_push) begin
            gap_q.push_back(cyc - last_push - 1);
            have_push <= 1'b0;
         end
         if (prev_apb_pend && (!bus.aud_PSEL || bus.aud_PWRITE != prev_pwrite))
            proto_viol <= proto_viol + 1;
         prev_apb_pend <= bus.aud_PSEL && !(bus.aud_PENABLE && bus.aud_PREADY);
         prev_pwrite   <= bus.aud_PWRITE;
         if (prev_mem_pend && (!bus.mem_req || bus.mem_addr != prev_maddr))
            addr_unstable <= addr_unstable + 1;
         prev_mem_pend <= bus.mem_req && !bus.mem_ack;
         prev_maddr    <= bus.mem_addr;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.cfg_PSEL = 1'b1; bus.cfg_PENABLE = 1'b0; bus.cfg_PWRITE = 1'b1;
      bus.cfg_PADDR = a;   bus.cfg_PWDATA = d;
      @(negedge clk);
      bus.cfg_PENABLE = 1'b1;
      @(negedge clk);
      bus.cfg_PSEL = 1'b0; bus.cfg_PENABLE = 1'b0; bus.cfg_PWRITE = 1'b0;
   endtask

   task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.cfg_PSEL = 1'b1; bus.cfg_PENABLE = 1'b0; bus.cfg_PWRITE = 1'b0;
      bus.cfg_PADDR = a;
      @(negedge clk);
      bus.cfg_PENABLE = 1'b1;
      d = bus.cfg_PRDATA;
      @(negedge clk);
      bus.cfg_PSEL = 1'b0; bus.cfg_PENABLE = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      logic [31:0] st;
      int t = 0;
      st = 32'd1;
      while (st[0] && t < budget) begin
         cfg_read(4'hC, st);
         t++;
      end
      check(tag, 32'(st[0]), 32'd0);
   endtask

   task automatic wait_writes(input int n, input int budget, input string tag);
      int t = 0;
      while (wr_q.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(tag, 32'(wr_q.size() >= n), 32'd1);
   endtask

   // Expected stream: word i comes from base + 4*(i mod len).
   task automatic check_stream(input string tag, input logic [31:0] base, input int len,
                               input int r0, input int w0, input int n);
      logic [31:0] exp_a, obs_a, obs_d;
      for (int i = 0; i < n; i++) begin
         exp_a = base + 32'(4 * (i % len));
         obs_a = (r0 + i < rd_q.size()) ? rd_q[r0 + i] : 32'hxxxxxxxx;
         obs_d = (w0 + i < wr_q.size()) ? wr_q[w0 + i] : 32'hxxxxxxxx;
         check($sformatf("%s_addr%0d", tag, i), obs_a, exp_a);
         check($sformatf("%s_data%0d", tag, i), obs_d, mem_arr[exp_a[7:2]]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, w0, p0, g0, a0, t, n_lt, n_eq, wstall;
      bit found;
      logic [31:0] st, base2;

      bus.cfg_PSEL = 0; bus.cfg_PENABLE = 0; bus.cfg_PWRITE = 0;
      bus.cfg_PADDR = 0; bus.cfg_PWDATA = 0;
      stall_push = 0; remaining = 1023; zero_until = 0; mem_delay = 0;
      for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;

      // Reset values
      reset = 1'b1;
      #3 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctl", {27'd0, bus.mem_req, bus.aud_PSEL, bus.aud_PENABLE, bus.aud_PWRITE, irq}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_paddr", 32'(bus.aud_PADDR), 32'd0);
      check("rst_pwdata", bus.aud_PWDATA, 32'd0);
      reset = 1'b1;
      cfg_read(4'hC, st);
      check("rst_status", st, 32'd0);

      // T1: basic three-word transfer with interrupt
      r0 = rd_q.size(); w0 = wr_q.size();
      cfg_write(4'h4, 32'h1000);
      cfg_write(4'h8, 32'd3);
      cfg_write(4'h0, 32'h5);
      wait_idle(200, "t1_idle");
      check("t1_nwr", 32'(wr_q.size() - w0), 32'd3);
      check_stream("t1", 32'h1000, 3, r0, w0, 3);
      cfg_read(4'hC, st);
      check("t1_status", st, {16'd3, 14'd0, 1'b1, 1'b0});
      check("t1_irq", 32'(irq), 32'd1);

      // Done clear: interrupt follows one cycle later
      cfg_write(4'hC, 32'h2);
      check("clr_irq_hold", 32'(irq), 32'd1);
      @(negedge clk);
      check("clr_irq_drop", 32'(irq), 32'd0);
      cfg_read(4'hC, st);
      check("clr_done", 32'(st[1]), 32'd0);

      // T2: remaining=2 forces credit-limited bursts and polling gaps
      remaining = 2;
      mem_delay = $urandom_range(0, 3);
      base2 = 32'h2000 + (32'($urandom_range(0, 63)) << 2);
      r0 = rd_q.size(); w0 = wr_q.size(); p0 = polls; g0 = gap_q.size();
      cfg_write(4'h4, base2);
      cfg_write(4'h8, 32'd5);
      cfg_write(4'h0, 32'h1);
      wait_idle(400, "t2_idle");
      check("t2_nwr", 32'(wr_q.size() - w0), 32'd5);
      check_stream("t2", base2, 5, r0, w0, 5);
      check("t2_polls", 32'(polls - p0), 32'd3);
      check("t2_overflow", 32'(ovf), 32'd0);
      n_lt = 0; n_eq = 0;
      for (int i = g0; i < gap_q.size(); i++) begin
         if (gap_q[i] < POLL_GAP) n_lt++;
         if (gap_q[i] == POLL_GAP) n_eq++;
      end
      check("t2_gap_short", 32'(n_lt), 32'd0);
      check("t2_gap_exact", 32'(n_eq), 32'd2);
      cfg_read(4'hC, st);
      check("t2_done", 32'(st[1:0]), 32'd2);
      check("t2_irq_masked", 32'(irq), 32'd0);

      // T3: ten zero-credit polls, then credit 4
      cfg_write(4'hC, 32'h2);
      remaining = 4; zero_until = polls + 10;
      mem_delay = $urandom_range(0, 2);
      r0 = rd_q.size(); w0 = wr_q.size(); p0 = polls;
      cfg_write(4'h4, 32'h1000);
      cfg_write(4'h8, 32'd4);
      cfg_write(4'h0, 32'h1);
      wait_idle(800, "t3_idle");
      check("t3_polls", 32'(polls - p0), 32'd11);
      check("t3_req_no_credit", 32'(req_no_credit), 32'd0);
      check("t3_nwr", 32'(wr_q.size() - w0), 32'd4);
      check_stream("t3", 32'h1000, 4, r0, w0, 4);

      // T4: looping transfer, then abort while a push is stalled
      cfg_write(4'hC, 32'h2);
      remaining = 1023;
      mem_delay = $urandom_range(0, 3);
      r0 = rd_q.size(); w0 = wr_q.size();
      cfg_write(4'h4, 32'h1000);
      cfg_write(4'h8, 32'd2);
      cfg_write(4'h0, 32'h3);
      wait_writes(w0 + 6, 400, "t4_progress");
      check_stream("t4", 32'h1000, 2, r0, w0, 6);
      cfg_read(4'hC, st);
      check("t4_busy_nodone", 32'(st[1:0]), 32'd1);
      stall_push = 1'b1;
      found = 0; t = 0;
      while (!found && t < 200) begin
         @(negedge clk);
         t++;
         if (bus.aud_PSEL && bus.aud_PENABLE && bus.aud_PWRITE) found = 1;
      end
      check("t4_stall_seen", 32'(found), 32'd1);
      wstall = wr_q.size();
      cfg_write(4'h0, 32'h0);
      check("t4_abort_hold", {29'd0, bus.aud_PSEL, bus.aud_PENABLE, bus.aud_PWRITE}, 32'd7);
      check("t4_abort_pending", 32'(wr_q.size()), 32'(wstall));
      stall_push = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_abort_completed", 32'(wr_q.size()), 32'(wstall + 1));
      check("t4_no_extra_fetch", 32'(rd_q.size() - r0), 32'(wr_q.size() - w0));
      cfg_read(4'hC, st);
      check("t4_abort_status", 32'(st[1:0]), 32'd0);
      check("t4_protocol", 32'(proto_viol), 32'd0);

      // T5: slow memory, request must hold stable
      mem_delay = 7;
      base2 = 32'h3000 + (32'($urandom_range(0, 63)) << 2);
      r0 = rd_q.size(); w0 = wr_q.size();
      cfg_write(4'h4, base2);
      cfg_write(4'h8, 32'd3);
      cfg_write(4'h0, 32'h5);
      wait_idle(400, "t5_idle");
      check_stream("t5", base2, 3, r0, w0, 3);
      check("t5_addr_stable", 32'(addr_unstable), 32'd0);
      check("t5_irq", 32'(irq), 32'd1);

      // Reset asserted mid-FETCH
      mem_delay = 20;
      cfg_write(4'h8, 32'd4);
      cfg_write(4'h0, 32'h5);
      found = 0; t = 0;
      while (!found && t < 100) begin
         @(negedge clk);
         t++;
         if (bus.mem_req) found = 1;
      end
      check("rst2_fetch_seen", 32'(found), 32'd1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst2_ctl", {27'd0, bus.mem_req, bus.aud_PSEL, bus.aud_PENABLE, bus.aud_PWRITE, irq}, 32'd0);
      check("rst2_mem_addr", bus.mem_addr, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cfg_read(4'hC, st);
      check("rst2_status", st, 32'd0);

      // LEN=0 start: immediate done, no bus traffic
      a0 = act_cycles;
      cfg_write(4'h8, 32'd0);
      cfg_write(4'h0, 32'h5);
      repeat (5) @(negedge clk);
      check("len0_no_activity", 32'(act_cycles - a0), 32'd0);
      cfg_read(4'hC, st);
      check("len0_status", st, 32'h2);
      check("len0_irq", 32'(irq), 32'd1);

      check("final_overflow", 32'(ovf), 32'd0);
      check("final_protocol", 32'(proto_viol), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/audio_dma.md
Name: audio_dma

Overview:
- Upstream feeder for the audio DAC controller.
- Software programs a base address and a length in 32-bit stereo words.
- The block fetches words from memory over a simple req/ack read port and pushes them to the controller's stream register through an APB master port.
- It paces writes by polling the controller's FIFO free-space count ("remaining"), so the FIFO never overflows. It raises an interrupt when a non-looping transfer completes.

Parameters:
STREAM_ADDR, 3'd4, APB address of controller stream register; a read of it returns remaining.
MAX_CREDIT, 16, cap on words pushed per poll.
POLL_GAP, 2, idle cycles between last push access phase and next poll setup phase.

Ports:
clk  in  1  system clock
reset  in  1  reset; asynchronous, active-low
cfg_PADDR  in  4  config register byte address (0x0 CTRL, 0x4 BASE, 0x8 LEN, 0xC STATUS)
cfg_PSEL  in  1  APB select
cfg_PENABLE  in  1  APB enable
cfg_PWRITE  in  1  APB write
cfg_PWDATA  in  32  APB write data
cfg_PRDATA  out  32  APB read data
cfg_PREADY  out  1  tied 1
mem_req  out  1  read request, held until mem_ack
mem_addr  out  32  word-aligned byte address
mem_ack  in  1  one-cycle; mem_rdata valid same cycle
mem_rdata  in  32  {right[15:0], left[15:0]}
aud_PADDR  out  3  to controller
aud_PSEL  out  1  to controller
aud_PENABLE  out  1  to controller
aud_PWRITE  out  1  to controller
aud_PWDATA  out  32  to controller
aud_PRDATA  in  32  from controller; low 10 bits = remaining
aud_PREADY  in  1  from controller; access completes when 1
interrupt  out  1  level, sticky done && irq_en

Behaviour:
- Clock is clk; reset is asynchronous and active-low.
- Reset clears every register. All outputs are 0 at reset: mem_req, aud_PSEL, aud_PENABLE, aud_PWRITE, interrupt; address and data outputs are also 0. State=IDLE.
- CTRL register:
  - bit0 enable: writing 1 from IDLE starts a transfer; writing 0 aborts.
  - bit1 loop.
  - bit2 irq_en.
- BASE[31:2] is the base word address. LEN[15:0] is the word count.
- STATUS:
  - bit0 busy (state != IDLE).
  - bit1 done, sticky; a write of 1 to bit1 clears it.
  - [31:16] words pushed.
- Config APB is zero-wait; reads return the current register values.
- Datapath registers: ptr (word offset), credit (0..MAX_CREDIT), gap counter, data latch.
- States and transitions:
  - IDLE: on enable write with LEN!=0, set ptr=0, credit=0, go to POLL_S. If LEN==0, set done immediately and stay in IDLE.
  - POLL_S: aud_PSEL=1, PADDR=STREAM_ADDR, PWRITE=0, PENABLE=0 for one cycle. Then POLL_A.
  - POLL_A: PSEL=1, PENABLE=1. When aud_PREADY=1, set credit=min(PRDATA[9:0], MAX_CREDIT). If the result is 0, go to GAP; otherwise go to FETCH.
  - FETCH: mem_req=1, mem_addr=BASE+4*ptr. On mem_ack, latch mem_rdata and go to PUSH_S.
  - PUSH_S: PSEL=1, PWRITE=1, PWDATA=latched word. Then PUSH_A.
  - PUSH_A: PENABLE=1. When aud_PREADY=1:
    - increment ptr and words pushed; decrement credit.
    - If ptr+1==LEN: when loop=1, wrap ptr to 0 and continue; otherwise set done and go to IDLE.
    - Else if credit-1==0, go to GAP.
    - Else go to FETCH.
  - GAP: wait POLL_GAP cycles, then POLL_S. The gap exists because the controller's remaining value lags its FIFO write pointer by 2 cycles.
- Credit is never refreshed except from a poll, so pushes never exceed the free space last reported.
- Abort (enable written 0):
  - If no APB access or memory request is in flight, go to IDLE immediately.
  - Otherwise finish the in-flight APB access or mem_req handshake (do not drop PSEL or mem_req mid-transaction), then go to IDLE. The word is discarded if it was not yet pushed.
  - done is not set on abort.
- An enable write while busy has no effect on progress; CTRL bits loop and irq_en update live.
- interrupt = done & irq_en, registered, 1-cycle latency from the done update.
- Simultaneous done-set and software clear in the same cycle: set wins.
- ptr is 16 bits; the address sum wraps modulo 2^32.

Test Plan:
- BASE=0x1000, LEN=3, controller reports remaining=1023 → reads at 0x1000, 0x1004, 0x1008; three stream writes with matching data; done=1, busy=0; interrupt=1 with irq_en.
- remaining=2, LEN=5 → 2 pushes, then a poll; no poll setup within POLL_GAP cycles after the last push; total 5 writes; the FIFO never overflows.
- remaining=0 for 10 polls, then 4 → no mem_req during zero credit; the transfer resumes afterward.
- loop=1, LEN=2 → addresses 0x1000, 0x1004, 0x1000, …; done stays 0. Abort during PUSH_A with PREADY held low 3 cycles → the access completes, then IDLE, done=0.
- mem_ack delayed 7 cycles → mem_req and mem_addr held stable throughout. Assert reset mid-FETCH → all outputs 0 immediately, state IDLE.
- STATUS write 0x2 while done=1 → done=0, interrupt deasserts next cycle. LEN=0 start → done=1, no bus activity.
